// File: rtl/shift_reg_seq.sv
// Command sequencer in front of the systolic-array operand shift register.
// FILL streams words in, PLOAD pulses a parallel load, DRAIN rotates the words out.
module shift_reg_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [DATA_WIDTH-1:0] m_data,
    output logic [1:0]                   ctrl_code,
    output logic signed [DATA_WIDTH-1:0] data_write,
    input  logic signed [DATA_WIDTH-1:0] data_read,
    output logic                         busy,
    output logic                         op_done
);
    localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

    localparam logic [1:0] CODE_UPLOAD = 2'd0;
    localparam logic [1:0] CODE_LOAD   = 2'd1;
    localparam logic [1:0] CODE_WRITE  = 2'd2;
    localparam logic [1:0] CODE_READ   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PLOAD,
        S_DR_ISSUE,
        S_DR_OUT
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic            r_op_done;
    logic            w_op_done_next;
    logic            w_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_op_done <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_op_done <= w_op_done_next;
        end
    end

    assign w_last = (r_count == LAST);

    // Every non-IDLE code is tied to its state, so an async reset forces UPLOAD at once.
    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_op_done_next = 1'b0;
        cmd_ready      = 1'b0;
        s_ready        = 1'b0;
        m_valid        = 1'b0;
        m_data         = '0;
        ctrl_code      = CODE_UPLOAD;
        data_write     = '0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_count_next = '0;
                    case (cmd_op)
                        2'd0:    w_state_next = S_FILL;
                        2'd1:    w_state_next = S_PLOAD;
                        2'd2:    w_state_next = S_DR_ISSUE;
                        default: w_op_done_next = 1'b1;
                    endcase
                end
            end
            S_FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    ctrl_code  = CODE_WRITE;
                    data_write = s_data;
                    if (w_last) begin
                        w_count_next   = '0;
                        w_state_next   = S_IDLE;
                        w_op_done_next = 1'b1;
                    end else begin
                        w_count_next = r_count + CW'(1);
                    end
                end
            end
            S_PLOAD: begin
                ctrl_code      = CODE_LOAD;
                w_state_next   = S_IDLE;
                w_op_done_next = 1'b1;
            end
            S_DR_ISSUE: begin
                ctrl_code    = CODE_READ;
                w_state_next = S_DR_OUT;
            end
            S_DR_OUT: begin
                // data_read stays put here because no READ is issued while waiting.
                m_valid = 1'b1;
                m_data  = data_read;
                if (m_ready) begin
                    if (w_last) begin
                        w_count_next   = '0;
                        w_state_next   = S_IDLE;
                        w_op_done_next = 1'b1;
                    end else begin
                        w_count_next = r_count + CW'(1);
                        w_state_next = S_DR_ISSUE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign busy    = (r_state != S_IDLE);
    assign op_done = r_op_done;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: a simple shift-register model on the far side, a
// transaction-level reference checked every cycle, and directed literal checks.
module tb_shift_reg_seq;
    localparam int DW = 8;
    localparam int L  = 4;

    logic                 clk        = 1'b0;
    logic                 reset_n    = 1'b1;
    logic                 cmd_valid  = 1'b0;
    logic [1:0]           cmd_op     = 2'd3;
    logic                 cmd_ready;
    logic                 s_valid    = 1'b0;
    logic                 s_ready;
    logic signed [DW-1:0] s_data     = '0;
    logic                 m_valid;
    logic                 m_ready    = 1'b0;
    logic signed [DW-1:0] m_data;
    logic [1:0]           ctrl_code;
    logic signed [DW-1:0] data_write;
    logic signed [DW-1:0] data_read  = '0;
    logic                 busy;
    logic                 op_done;

    int checks = 0;
    int errors = 0;

    shift_reg_seq #(.DATA_WIDTH(DW), .LENGTH(L)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .ctrl_code  (ctrl_code),
        .data_write (data_write),
        .data_read  (data_read),
        .busy       (busy),
        .op_done    (op_done)
    );

    always #5 clk = ~clk;

    // Operand shift register: WRITE shifts in at the top, READ rotates element 0 out.
    logic signed [DW-1:0] sr [L] = '{default: '0};
    always @(posedge clk) begin
        case (ctrl_code)
            2'd2: begin
                for (int i = 0; i < L - 1; i++) sr[i] <= sr[i+1];
                sr[L-1] <= data_write;
            end
            2'd3: begin
                data_read <= sr[0];
                for (int i = 0; i < L - 1; i++) sr[i] <= sr[i+1];
                sr[L-1] <= sr[0];
            end
            default: ;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: op in progress (-1 none), words left, and the register contents
    // as last written by a completed FILL (DRAIN must return them unchanged).
    int  m_op       = -1;
    int  m_left     = 0;
    bit  rd_pending = 1'b0;
    bit  exp_done   = 1'b0;
    logic signed [DW-1:0] ref_mem  [L] = '{default: '0};
    logic signed [DW-1:0] fill_buf [L] = '{default: '0};

    int write_cnt = 0, load_cnt = 0, read_cnt = 0, done_cnt = 0;
    int stall_cnt = 0, stall_bad = 0, cyc = 0;
    int hs_first = 0, hs_last = 0, hs_in_op = 0;
    int last_done_cyc = 0, prev_done_cyc = 0;
    logic signed [DW-1:0] got_q [$];

    always @(negedge clk) begin : compare
        int exp_ctrl;
        int exp_dw;
        bit exp_mv;
        bit next_done;
        cyc++;
        if (!reset_n) begin
            check("rst_ctrl_code", int'(ctrl_code), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_op_done", int'(op_done), 0);
            check("rst_cmd_ready", int'(cmd_ready), 1);
            check("rst_m_valid", int'(m_valid), 0);
            check("rst_data_write", int'(data_write), 0);
            m_op = -1; m_left = 0; rd_pending = 1'b0; exp_done = 1'b0;
        end else begin
            exp_ctrl = 0; exp_dw = 0; exp_mv = 1'b0; next_done = 1'b0;
            case (m_op)
                0: if (s_valid) begin exp_ctrl = 2; exp_dw = int'(s_data); end
                1: exp_ctrl = 1;
                2: if (!rd_pending) exp_ctrl = 3; else exp_mv = 1'b1;
                default: ;
            endcase
            check("busy", int'(busy), int'(m_op != -1));
            check("cmd_ready", int'(cmd_ready), int'(m_op == -1));
            check("s_ready", int'(s_ready), int'(m_op == 0));
            check("op_done", int'(op_done), int'(exp_done));
            check("ctrl_code", int'(ctrl_code), exp_ctrl);
            check("data_write", int'(data_write), exp_dw);
            check("m_valid", int'(m_valid), int'(exp_mv));
            if (exp_mv) check("m_data", int'(m_data), int'(ref_mem[L - m_left]));

            if (ctrl_code == 2'd2) write_cnt++;
            if (ctrl_code == 2'd1) load_cnt++;
            if (ctrl_code == 2'd3) read_cnt++;
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                if (hs_in_op == 0) hs_first = cyc;
                hs_last = cyc;
                hs_in_op++;
                $display("drain word %0d at cycle %0d", m_data, cyc);
            end
            if (m_valid && !m_ready) begin
                stall_cnt++;
                if (m_data != -8'sd3) stall_bad++;
            end
            if (op_done) begin
                done_cnt++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
            end

            case (m_op)
                -1: if (cmd_valid) begin
                    if (cmd_op == 2'd3) next_done = 1'b1;
                    else begin
                        m_op = int'(cmd_op); m_left = L; rd_pending = 1'b0; hs_in_op = 0;
                    end
                end
                0: if (s_valid) begin
                    fill_buf[L - m_left] = s_data;
                    m_left--;
                    if (m_left == 0) begin
                        for (int i = 0; i < L; i++) ref_mem[i] = fill_buf[i];
                        m_op = -1; next_done = 1'b1;
                    end
                end
                1: begin m_op = -1; next_done = 1'b1; end
                2: if (!rd_pending) rd_pending = 1'b1;
                   else if (m_ready) begin
                       rd_pending = 1'b0;
                       m_left--;
                       if (m_left == 0) begin m_op = -1; next_done = 1'b1; end
                   end
                default: ;
            endcase
            exp_done = next_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout actual=0 required=1 op=%0d", op);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd3;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!op_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!op_done) begin
            checks++; errors++;
            $display("FAIL %s_done_timeout actual=0 required=1", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill_word(input logic signed [DW-1:0] w, input int gap);
        s_valid = 1'b0;
        s_data  = 8'sh63;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data  = w;
        tick();
        s_valid = 1'b0;
        s_data  = 8'sh63;
    endtask

    logic signed [DW-1:0] fill_a [L] = '{8'sh05, 8'shFD, 8'sh07, 8'sh80};
    logic signed [DW-1:0] fill_b [L] = '{8'sh0A, 8'shEC, 8'sh1E, 8'shD8};
    int gaps_a [L] = '{0, 2, 1, 0};
    int gaps_b [L] = '{1, 0, 0, 1};

    initial begin : stim
        int w0, d0, r0, l0, nz0, s0, sb0, base, n;
        #1 reset_n = 1'b0;
        #1;
        check("reset ctrl_code", int'(ctrl_code), 0);
        check("reset busy", int'(busy), 0);
        check("reset cmd_ready", int'(cmd_ready), 1);
        check("reset m_valid", int'(m_valid), 0);
        check("reset op_done", int'(op_done), 0);
        check("reset m_data", int'(m_data), 0);
        #30 reset_n = 1'b1;
        tick();
        check("idle ctrl_code", int'(ctrl_code), 0);
        check("idle busy", int'(busy), 0);
        check("idle cmd_ready", int'(cmd_ready), 1);
        check("idle s_ready", int'(s_ready), 0);
        check("idle op_done", int'(op_done), 0);

        // s_valid / m_ready outside their states must do nothing
        w0 = write_cnt;
        s_valid = 1'b1; s_data = 8'sh37; m_ready = 1'b1;
        tick(); tick();
        s_valid = 1'b0; m_ready = 1'b0;
        check("idle s_valid ignored", write_cnt - w0, 0);

        // FILL 5,-3,7,-128 with gaps
        w0 = write_cnt; d0 = done_cnt;
        send_cmd(2'd0);
        for (int i = 0; i < L; i++) fill_word(fill_a[i], gaps_a[i]);
        wait_done("fill1");
        check("fill1 write cycles", write_cnt - w0, 4);
        check("fill1 done pulses", done_cnt - d0, 1);

        // DRAIN with m_ready=1
        base = got_q.size(); r0 = read_cnt; d0 = done_cnt;
        m_ready = 1'b1;
        send_cmd(2'd2);
        wait_done("drain1");
        check("drain1 words", got_q.size() - base, 4);
        for (int i = 0; i < L; i++)
            if (got_q.size() > base + i) check("drain1 word", int'(got_q[base+i]), int'(fill_a[i]));
        check("drain1 reads", read_cnt - r0, 4);
        check("drain1 spacing", hs_last - hs_first, 6);
        check("drain1 done pulses", done_cnt - d0, 1);

        // second DRAIN with a 5-cycle stall on the second word
        base = got_q.size(); r0 = read_cnt; s0 = stall_cnt; sb0 = stall_bad;
        send_cmd(2'd2);
        n = 0;
        while (got_q.size() < base + 1 && n < 20) begin tick(); n++; end
        m_ready = 1'b0;
        repeat (6) tick();
        m_ready = 1'b1;
        wait_done("drain2");
        check("drain2 stall cycles", stall_cnt - s0, 5);
        check("drain2 stall data", stall_bad - sb0, 0);
        check("drain2 reads", read_cnt - r0, 4);
        check("drain2 words", got_q.size() - base, 4);
        for (int i = 0; i < L; i++)
            if (got_q.size() > base + i) check("drain2 word", int'(got_q[base+i]), int'(fill_a[i]));

        // PLOAD, then a NOP held across busy and accepted in the op_done cycle
        l0 = load_cnt; d0 = done_cnt; nz0 = write_cnt + load_cnt + read_cnt;
        send_cmd(2'd1);
        send_cmd(2'd3);
        wait_done("nop");
        check("pload load cycles", load_cnt - l0, 1);
        check("pload+nop nonzero codes", write_cnt + load_cnt + read_cnt - nz0, 1);
        check("pload+nop done pulses", done_cnt - d0, 2);
        check("nop back-to-back done gap", last_done_cyc - prev_done_cyc, 1);

        // reset mid-FILL after 2 words, with a third word presented
        send_cmd(2'd0);
        fill_word(8'sh11, 0);
        fill_word(8'sh22, 0);
        s_valid = 1'b1; s_data = 8'sh33;
        #1;
        check("prefault ctrl_code", int'(ctrl_code), 2);
        d0 = done_cnt;
        #1 reset_n = 1'b0;
        #1;
        check("midreset ctrl_code", int'(ctrl_code), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset data_write", int'(data_write), 0);
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (3) tick();
        check("midreset no op_done", done_cnt - d0, 0);

        // fresh FILL and DRAIN after the abort
        w0 = write_cnt;
        send_cmd(2'd0);
        for (int i = 0; i < L; i++) fill_word(fill_b[i], gaps_b[i]);
        wait_done("fill2");
        check("fill2 write cycles", write_cnt - w0, 4);
        base = got_q.size();
        send_cmd(2'd2);
        wait_done("drain3");
        check("drain3 words", got_q.size() - base, 4);
        for (int i = 0; i < L; i++)
            if (got_q.size() > base + i) check("drain3 word", int'(got_q[base+i]), int'(fill_b[i]));

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_reg_seq.md
Name: shift_reg_seq

Overview:
Sequencer that sits directly upstream of the systolic-array wrapper's operand shift register and drives its ctrl_code and data_write inputs. It accepts one-word commands, then performs one of three operations. FILL streams LENGTH words from a valid/ready input into the register. PLOAD issues a one-cycle parallel load. DRAIN reads LENGTH words out of the register via REG_READ onto a valid/ready output stream.

Parameters:
DATA_WIDTH, 8, width of one element (matches shift register)
LENGTH, 4, number of elements in the shift register; >= 2

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  0=FILL, 1=PLOAD, 2=DRAIN, 3=NOP
s_valid  in  1  fill-stream word valid
s_ready  out  1  fill-stream ready
s_data  in  DATA_WIDTH  fill-stream word (signed)
m_valid  out  1  drain-stream word valid
m_ready  in  1  drain-stream ready
m_data  out  DATA_WIDTH  drain-stream word (signed)
ctrl_code  out  2  to shift register: 0=UPLOAD, 1=LOAD, 2=WRITE, 3=READ
data_write  out  DATA_WIDTH  to shift register data_write
data_read  in  DATA_WIDTH  from shift register data_read
busy  out  1  high whenever state != IDLE
op_done  out  1  one-cycle pulse, registered, when a command completes

Behaviour:
- One clock. Reset is asynchronous, active-low, on reset_n. All state and counters are cleared while reset_n=0.
- Reset values: state=IDLE, count=0, op_done=0. Outputs then read busy=0, cmd_ready=1, s_ready=0, m_valid=0, ctrl_code=0 (UPLOAD), data_write=0, m_data=0.
- The shift register acts on ctrl_code every cycle. The idle/no-op code is therefore UPLOAD (0), which is non-destructive. ctrl_code is never 1, 2 or 3 outside the states listed below.
- ctrl_code, data_write, s_ready, m_valid and m_data are decoded combinationally from the state register and live inputs. There is no extra latency stage.
- States: IDLE, FILL, PLOAD, DR_ISSUE, DR_OUT.
- IDLE:
  - cmd_ready=1.
  - On cmd handshake: op 0 -> FILL; 1 -> PLOAD; 2 -> DR_ISSUE; 3 -> stays IDLE with op_done=1 next cycle.
  - count cleared on every accept.
- FILL:
  - s_ready=1.
  - When s_valid=1: ctrl_code=WRITE, data_write=s_data, count++. Otherwise ctrl_code=UPLOAD and data_write=0.
  - On the handshake with count==LENGTH-1: -> IDLE, op_done=1 next cycle.
  - Word order: the first accepted word ends in element 0 and the last in element LENGTH-1.
- PLOAD: exactly one cycle with ctrl_code=LOAD, then -> IDLE, op_done=1 next cycle.
- DR_ISSUE: one cycle with ctrl_code=READ, m_valid=0, then -> DR_OUT.
- DR_OUT:
  - ctrl_code=UPLOAD, m_valid=1, m_data=data_read (passthrough; data_read is stable because no READ is issued).
  - Holds while m_ready=0, with m_data stable.
  - On handshake: count++. If count==LENGTH-1 -> IDLE with op_done=1 next cycle, else -> DR_ISSUE.
  - Throughput is one word per 2 cycles.
- DRAIN rotates the register circularly. After LENGTH reads the contents equal their pre-drain values, so a second DRAIN returns the same sequence.
- Commands are never accepted while busy (cmd_ready=0). A command held across busy is accepted in the first IDLE cycle, which is the cycle op_done is high (back-to-back allowed).
- s_valid is ignored outside FILL. m_ready is ignored outside DR_OUT.
- Reset asserted mid-operation aborts immediately to IDLE. No op_done is produced, and ctrl_code is forced to UPLOAD asynchronously.
- count width is clog2(LENGTH) bits minimum; it never wraps during an operation.

Test Plan:
- Reset then idle: hold reset_n=0 for 3 cycles mid-clock, release -> ctrl_code=0, busy=0, cmd_ready=1, m_valid=0, op_done=0.
- FILL then DRAIN, LENGTH=4, stream 5,-3,7,-128 with s_valid gaps; then DRAIN with m_ready=1:
  - WRITE is issued only on the 4 handshake cycles; op_done pulses once.
  - Drain emits 5,-3,7,-128 (one word every 2 cycles), then op_done.
- Drain backpressure: m_ready=0 for 5 cycles on the second word -> m_valid held, m_data held at -3, no READ issued, ctrl_code=0 throughout the stall.
- Rotation check: DRAIN twice after the FILL above -> both passes emit 5,-3,7,-128.
- PLOAD and NOP:
  - cmd_op=1 -> exactly one cycle of ctrl_code=1, op_done one cycle later.
  - cmd_op=3 -> no non-zero ctrl_code, op_done the next cycle.
  - A back-to-back command is accepted in the op_done cycle.
- Reset mid-FILL after 2 words -> ctrl_code=0 immediately, busy=0, no op_done. A new FILL of 4 words then completes normally with a fresh count.
